// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nand_full_adder.sv
// One-bit full adder built from nine Sheffer (NAND) cells.
module nand_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic n1, n2, n3, axb, n5, n6, n7;

  // First half adder: axb = a ^ b, n1 = ~(a & b)
  sheffer u_n1 (.a(a),   .b(b),   .y(n1));
  sheffer u_n2 (.a(a),   .b(n1),  .y(n2));
  sheffer u_n3 (.a(b),   .b(n1),  .y(n3));
  sheffer u_n4 (.a(n2),  .b(n3),  .y(axb));

  // Second half adder against cin; carry merges both NAND carry terms
  sheffer u_n5 (.a(axb), .b(cin), .y(n5));
  sheffer u_n6 (.a(axb), .b(n5),  .y(n6));
  sheffer u_n7 (.a(cin), .b(n5),  .y(n7));
  sheffer u_n8 (.a(n6),  .b(n7),  .y(s));
  sheffer u_n9 (.a(n5),  .b(n1),  .y(cout));

endmodule

// File: rtl/sheffer.sv
// Two-input NAND (Sheffer stroke) primitive.
module sheffer (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder with valid/ready on both sides; one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
  logic             fa_s, fa_cout;

  nand_full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (cy),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        last_bit = (cnt == LAST);
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter holds at WIDTH-1 after the last bit; only an accept reloads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      cy     <= fa_cout;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  assign sum   = sum_sr;
  assign carry = cy;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf;

  // Carry into the MSB is still in cy on the final edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (accept)   ovf <= 1'b0;
    else if (last_bit) ovf <= cy ^ fa_cout;
  end

  assign overflow = ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
// Define SERIAL_ADDER_OVERFLOW_EN to also exercise the overflow output.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = model_add(x, y);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Stimulus helpers only; all checks live in the test tasks
  task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, output logic rdy);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int unsigned lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, carry, sum} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b carry=%0b sum=%0h required 0/0/0", out_valid, carry, sum);
    end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_overflow: got %0b required 0", overflow);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] xs [3] = '{8'h0F, 8'hFF, 8'hA5};
    logic [W-1:0] ys [3] = '{8'h01, 8'h01, 8'h5A};
    logic rdy;
    int unsigned lat;
    logic [W:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = model_add(xs[i], ys[i]);
      start_add(xs[i], ys[i], rdy);
      n_cmp++;
      if (rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL dir_accept_ready[%0d]: got %0b required 1", i, rdy);
      end
      wait_done(lat);
      n_cmp++;
      if (lat !== W) begin
        n_bad++;
        $display("FAIL dir_latency[%0d]: got %0d required %0d", i, lat, W);
      end
      n_cmp++;
      if ({carry, sum} !== exp || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got carry=%0b sum=%0h in_ready=%0b required %0b/%0h/0",
                 i, carry, sum, in_ready, exp[W], exp[W-1:0]);
      end
      release_result();
      n_cmp++;
      if ({out_valid, in_ready, carry, sum} !== {1'b0, 1'b1, exp}) begin
        n_bad++;
        $display("FAIL dir_idle_hold[%0d]: got valid=%0b rdy=%0b carry=%0b sum=%0h required 0/1/%0b/%0h",
                 i, out_valid, in_ready, carry, sum, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_back_pressure;
    logic rdy;
    int unsigned lat;
    logic [W:0] exp;
    exp = model_add(8'hC3, 8'h4E);
    start_add(8'hC3, 8'h4E, rdy);
    wait_done(lat);
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, carry, sum} !== {1'b1, 1'b0, exp}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%0b rdy=%0b carry=%0b sum=%0h required 1/0/%0b/%0h",
                 c, out_valid, in_ready, carry, sum, exp[W], exp[W-1:0]);
      end
    end
    // in_valid still high on the release edge: only out_ready may act
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, carry, sum} !== {1'b0, 1'b1, exp}) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%0b rdy=%0b carry=%0b sum=%0h required 0/1/%0b/%0h",
               out_valid, in_ready, carry, sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_ignore_in_valid;
    logic rdy;
    int unsigned lat;
    start_add(8'h01, 8'h02, rdy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h33;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL run_in_ready: got %0b required 0", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    n_cmp++;
    if (lat !== W - 5) begin
      n_bad++;
      $display("FAIL run_latency: got %0d required %0d", lat, W - 5);
    end
    n_cmp++;
    if ({carry, sum} !== {1'b0, 8'h03}) begin
      n_bad++;
      $display("FAIL run_ignore: got carry=%0b sum=%0h required 0/03", carry, sum);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run;
    logic rdy;
    int unsigned lat;
    int unsigned highs;
    start_add(8'hFF, 8'hFF, rdy);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, carry, sum} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: got valid=%0b carry=%0b sum=%0h required 0/0/0", out_valid, carry, sum);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < W + 2; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    n_cmp++;
    if (highs !== 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_no_valid: got %0d valid cycles, in_ready=%0b required 0 and 1", highs, in_ready);
    end
    start_add(8'h80, 8'h80, rdy);
    wait_done(lat);
    n_cmp++;
    if ({carry, sum} !== {1'b1, 8'h00} || lat !== W) begin
      n_bad++;
      $display("FAIL abort_next_add: got carry=%0b sum=%0h lat=%0d required 1/00/%0d", carry, sum, lat, W);
    end
    release_result();
  endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
  task automatic test_overflow;
    logic [W-1:0] xs [2] = '{8'h7F, 8'hFF};
    logic [W-1:0] ys [2] = '{8'h01, 8'hFF};
    logic [W+1:0] req [2] = '{{1'b1, 1'b0, 8'h80}, {1'b0, 1'b1, 8'hFE}};
    logic rdy;
    int unsigned lat;
    for (int i = 0; i < 2; i++) begin
      start_add(xs[i], ys[i], rdy);
      n_cmp++;
      if (overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL ovf_clear[%0d]: got %0b required 0", i, overflow);
      end
      wait_done(lat);
      n_cmp++;
      if ({overflow, carry, sum} !== req[i]) begin
        n_bad++;
        $display("FAIL ovf_result[%0d]: got ovf=%0b carry=%0b sum=%0h required %0h",
                 i, overflow, carry, sum, req[i]);
      end
      release_result();
    end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] x, y;
    logic [W:0] exp;
    logic rdy;
    int unsigned lat;
    int unsigned dly;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      dly = $urandom_range(0, 3);
      exp = model_add(x, y);
      out_ready = (dly == 0);
      start_add(x, y, rdy);
      wait_done(lat);
      n_cmp++;
      if ({carry, sum} !== exp || lat !== W || rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL rand[%0d] %0h+%0h: got carry=%0b sum=%0h lat=%0d rdy=%0b required %0b/%0h/%0d/1",
                 i, x, y, carry, sum, lat, rdy, exp[W], exp[W-1:0], W);
      end
`ifdef SERIAL_ADDER_OVERFLOW_EN
      n_cmp++;
      if (overflow !== model_ovf(x, y)) begin
        n_bad++;
        $display("FAIL rand_ovf[%0d] %0h+%0h: got %0b required %0b", i, x, y, overflow, model_ovf(x, y));
      end
`endif
      repeat (dly) @(posedge clk);
      #1;
      release_result();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_idle[%0d]: got valid=%0b rdy=%0b required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_ignore_in_valid();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
